// File: rtl/flow_zigzag.sv
`default_nettype none
// =====================================================================================
// flow_zigzag : raster-to-zigzag reorder of 8x8 coefficient blocks through ping-pong banks
//               optional eob framing check: FLOW_ZIGZAG_CHECK_EN        revision 1.0
// =====================================================================================
module flow_zigzag #(
    parameter int N = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic            in_valid_i,
    input  logic [N*16-1:0] in_data_i,
    input  logic            in_sob_i,
    input  logic            in_eob_i,
    input  logic            in_sof_i,
    output logic            out_valid_o,
    output logic [N*16-1:0] out_data_o,
    output logic            out_sob_o,
    output logic            out_eob_o,
    output logic            out_sof_o,
    output logic            out_err_o
);

    localparam int         K    = 64 / N;
    localparam logic [5:0] LAST = 6'(K - 1);

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wstate_t;

    wstate_t         w_state_q, w_state_d;
    logic [5:0]      wc_q, wc_d;
    logic            wbank_q, wbank_d;
    logic [1:0]      full_q, full_d;
    logic [1:0]      sof_q, sof_d;
    logic [5:0]      rc_q;
    logic            rbank_q;
    logic [15:0]     mem_q [0:127];

    logic            out_valid_q;
    logic [N*16-1:0] out_data_q;
    logic            out_sob_q;
    logic            out_eob_q;
    logic            out_sof_q;
    logic            out_err_q;

    logic            w_wr_en;
    logic [5:0]      w_pos;
    logic [5:0]      w_wr_base;
    logic            w_bad;
    logic            w_err;
    logic            w_rd_active;
    logic            w_rd_issue;
    logic            w_rd_last;
    logic [5:0]      w_rd_base;
    logic [N*16-1:0] w_rd_data;

`ifndef FLOW_ZIGZAG_CHECK_EN
    logic            w_eob_unused;
    assign w_eob_unused = in_eob_i;
`endif

    assign w_rd_active = full_q[rbank_q];
    assign w_rd_issue  = en_i & w_rd_active;
    assign w_rd_last   = (rc_q == LAST);
    assign w_rd_base   = rc_q * 6'(N);
    assign w_wr_base   = w_pos * 6'(N);

    // Writer: a sob beat always (re)starts at index 0 of the current write bank.
    always_comb begin
        w_state_d = w_state_q;
        wc_d      = wc_q;
        wbank_d   = wbank_q;
        full_d    = full_q;
        sof_d     = sof_q;
        w_wr_en   = 1'b0;
        w_pos     = wc_q;
        w_bad     = 1'b0;
        w_err     = 1'b0;

        if (en_i && in_valid_i) begin
            if (in_sob_i) begin
                w_pos = 6'd0;
                if (full_q[wbank_q]) begin
                    w_err     = 1'b1;
                    w_state_d = W_IDLE;
                    wc_d      = 6'd0;
                end else begin
                    w_wr_en          = 1'b1;
                    sof_d[wbank_q]   = in_sof_i;
                end
            end else if (w_state_q == W_FILL) begin
                w_wr_en = 1'b1;
            end
        end

`ifdef FLOW_ZIGZAG_CHECK_EN
        w_bad = w_wr_en && (in_eob_i != (w_pos == LAST));
`endif

        if (w_wr_en) begin
            if (w_bad) begin
                w_err     = 1'b1;
                w_state_d = W_IDLE;
                wc_d      = 6'd0;
            end else if (w_pos == LAST) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                w_state_d       = W_IDLE;
                wc_d            = 6'd0;
            end else begin
                w_state_d = W_FILL;
                wc_d      = w_pos + 6'd1;
            end
        end

        // The writer only ever completes the bank the reader is not draining.
        if (w_rd_issue && w_rd_last) begin
            full_d[rbank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q   <= W_IDLE;
            wc_q        <= 6'd0;
            wbank_q     <= 1'b0;
            full_q      <= 2'b00;
            sof_q       <= 2'b00;
            rc_q        <= 6'd0;
            rbank_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sob_q   <= 1'b0;
            out_eob_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            wc_q      <= wc_d;
            wbank_q   <= wbank_d;
            full_q    <= full_d;
            sof_q     <= sof_d;
            if (en_i) begin
                out_err_q   <= w_err;
                out_valid_q <= w_rd_active;
                out_data_q  <= w_rd_active ? w_rd_data : '0;
                out_sob_q   <= w_rd_active && (rc_q == 6'd0);
                out_eob_q   <= w_rd_active && w_rd_last;
                out_sof_q   <= w_rd_active && (rc_q == 6'd0) && sof_q[rbank_q];
                if (w_rd_active) begin
                    rc_q <= w_rd_last ? 6'd0 : rc_q + 6'd1;
                    if (w_rd_last) begin
                        rbank_q <= ~rbank_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < N; i++) begin
                mem_q[{wbank_q, w_wr_base + 6'(i)}] <= in_data_i[16*i +: 16];
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_rd_lane
        assign w_rd_data[16*j +: 16] = mem_q[{rbank_q, ZZ[w_rd_base + 6'(j)]}];
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sob_o   = out_sob_q;
    assign out_eob_o   = out_eob_q;
    assign out_sof_o   = out_sof_q;
    assign out_err_o   = out_err_q;

endmodule

`default_nettype wire

// File: tb/tb_flow_zigzag.sv
`default_nettype none
// tb_flow_zigzag: randomized bench; expected order comes from walking the 8x8 anti-diagonals.
module tb_flow_zigzag;

    localparam int N = 2;
    localparam int K = 64 / N;
    localparam int W = N * 16;

    typedef struct packed {
        logic [W-1:0] d;
        logic         sob;
        logic         eob;
        logic         sof;
    } beat_t;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         en       = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_sob   = 1'b0;
    logic         in_eob   = 1'b0;
    logic         in_sof   = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_sob;
    logic         out_eob;
    logic         out_sof;
    logic         out_err;

    int           total     = 0;
    int           bad       = 0;
    int           en_cyc    = 0;
    int           err_cnt   = 0;
    int           hold_viol = 0;
    int           zz [64];
    logic [15:0]  cur [64];
    beat_t        exp_q [$];
    beat_t        cap [$];
    int           cap_t [$];
    logic [W+4:0] prev_out = '0;

    flow_zigzag #(.N(N)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_sob_i    (in_sob),
        .in_eob_i    (in_eob),
        .in_sof_i    (in_sof),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_sob_o   (out_sob),
        .out_eob_o   (out_eob),
        .out_sof_o   (out_sof),
        .out_err_o   (out_err)
    );

    always #5 clk = ~clk;

    // One clock; records output beats on enabled edges and output changes on disabled ones.
    task automatic tick();
        logic         was_en;
        logic [W+4:0] now;
        was_en = en;
        @(posedge clk);
        #1;
        now = {out_valid, out_data, out_sob, out_eob, out_sof, out_err};
        if (was_en) begin
            en_cyc++;
            if (out_valid) begin
                cap.push_back(beat_t'({out_data, out_sob, out_eob, out_sof}));
                cap_t.push_back(en_cyc);
            end
            if (out_err) err_cnt++;
        end else if (rst_n && (now !== prev_out)) begin
            hold_viol++;
        end
        prev_out = now;
    endtask

    task automatic build_zz();
        int k, lo, hi, r;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            for (int t = 0; t <= hi - lo; t++) begin
                r = (s % 2 == 0) ? hi - t : lo + t;
                zz[k] = r * 8 + (s - r);
                k++;
            end
        end
    endtask

    task automatic fill(input int base, input bit rnd);
        for (int i = 0; i < 64; i++) cur[i] = rnd ? 16'($urandom) : 16'(base + i);
    endtask

    task automatic push_expected(input logic sof);
        beat_t e;
        for (int b = 0; b < K; b++) begin
            for (int j = 0; j < N; j++) e.d[16*j +: 16] = cur[zz[b*N+j]];
            e.sob = (b == 0);
            e.eob = (b == K - 1);
            e.sof = sof && (b == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_sob   = 1'b0;
        in_eob   = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
    endtask

    task automatic send_block(input logic sof, input int eob_at, input bit rand_en, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            if (rand_en) begin
                for (int g = 0; g < 6 && $urandom_range(1, 0) == 1; g++) begin
                    en       = 1'b0;
                    in_valid = 1'($urandom);
                    in_sob   = 1'($urandom);
                    in_eob   = 1'($urandom);
                    in_sof   = 1'b1;
                    in_data  = W'($urandom);
                    tick();
                end
            end
            en       = 1'b1;
            in_valid = 1'b1;
            in_sob   = (b == 0);
            in_eob   = (b == eob_at);
            in_sof   = (b == 0) ? sof : 1'($urandom);
            for (int j = 0; j < N; j++) in_data[16*j +: 16] = cur[b*N+j];
            tick();
        end
        idle_inputs();
    endtask

    task automatic drain(input int n);
        en = 1'b1;
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        cap.delete();
        cap_t.delete();
        exp_q.delete();
        err_cnt   = 0;
        hold_viol = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        idle_inputs();
        repeat (3) tick();
        total++;
        if ({out_valid, out_data, out_sob, out_eob, out_sof, out_err} !== '0) begin
            bad++;
            $display("FAIL reset_hold: outputs %h, want 0", {out_valid, out_data, out_sob, out_eob, out_sof, out_err});
        end
        rst_n = 1'b1;
        clear_logs();
        drain(4);
        total++;
        if (cap.size() != 0) begin
            bad++;
            $display("FAIL reset_idle_valid: %0d beats, want 0", cap.size());
        end
        total++;
        if (out_data !== '0 || err_cnt != 0) begin
            bad++;
            $display("FAIL reset_idle_data: data %h err %0d, want 0 and 0", out_data, err_cnt);
        end
    endtask

    task automatic test_single();
        int eob_t, first_t, span;
        clear_logs();
        fill(0, 1'b0);
        push_expected(1'b0);
        send_block(1'b0, K - 1, 1'b0, K);
        eob_t = en_cyc;
        drain(K + 6);
        total++;
        if (cap.size() != exp_q.size()) begin
            bad++;
            $display("FAIL single_count: %0d beats, want %0d", cap.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL single_beat%0d: got %h, want %h", i, cap[i], exp_q[i]);
            end
        end
        first_t = (cap_t.size() == 0) ? -1 : cap_t[0];
        span    = (cap_t.size() == 0) ? -1 : cap_t[cap_t.size()-1] - cap_t[0];
        total++;
        if (first_t != eob_t + 1) begin
            bad++;
            $display("FAIL single_latency: first beat at en-cycle %0d, want %0d", first_t, eob_t + 1);
        end
        total++;
        if (span != K - 1) begin
            bad++;
            $display("FAIL single_contiguous: span %0d, want %0d", span, K - 1);
        end
        total++;
        if (err_cnt != 0) begin
            bad++;
            $display("FAIL single_err: %0d pulses, want 0", err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int span;
        clear_logs();
        for (int b = 0; b < 3; b++) begin
            fill(100 * b, 1'b0);
            push_expected(b == 0);
            send_block(b == 0, K - 1, 1'b0, K);
        end
        drain(K + 6);
        total++;
        if (cap.size() != 3 * K) begin
            bad++;
            $display("FAIL b2b_count: %0d beats, want %0d", cap.size(), 3 * K);
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_beat%0d: got %h, want %h", i, cap[i], exp_q[i]);
            end
        end
        span = (cap_t.size() == 0) ? -1 : cap_t[cap_t.size()-1] - cap_t[0];
        total++;
        if (span != 3 * K - 1) begin
            bad++;
            $display("FAIL b2b_contiguous: span %0d, want %0d", span, 3 * K - 1);
        end
    endtask

    task automatic test_en_toggle();
        clear_logs();
        for (int b = 0; b < 2; b++) begin
            fill(0, 1'b1);
            push_expected(b == 0);
            send_block(b == 0, K - 1, 1'b1, K);
        end
        for (int c = 0; c < 120; c++) begin
            en = 1'($urandom);
            tick();
        end
        drain(2 * K + 4);
        total++;
        if (cap.size() != exp_q.size()) begin
            bad++;
            $display("FAIL en_count: %0d beats, want %0d", cap.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL en_beat%0d: got %h, want %h", i, cap[i], exp_q[i]);
            end
        end
        total++;
        if (hold_viol != 0) begin
            bad++;
            $display("FAIL en_hold: %0d output changes while disabled, want 0", hold_viol);
        end
    endtask

    task automatic test_eob_check();
        int want_err;
        clear_logs();
        fill(0, 1'b1);
`ifdef FLOW_ZIGZAG_CHECK_EN
        want_err = 1;
`else
        want_err = 0;
        push_expected(1'b0);
`endif
        send_block(1'b0, 20, 1'b0, K);
        fill(0, 1'b1);
        push_expected(1'b0);
        send_block(1'b0, K - 1, 1'b0, K);
        drain(K + 6);
        total++;
        if (cap.size() != exp_q.size()) begin
            bad++;
            $display("FAIL eobchk_count: %0d beats, want %0d", cap.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL eobchk_beat%0d: got %h, want %h", i, cap[i], exp_q[i]);
            end
        end
        total++;
        if (err_cnt != want_err) begin
            bad++;
            $display("FAIL eobchk_err: %0d pulses, want %0d", err_cnt, want_err);
        end
    endtask

    task automatic test_sob_restart();
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            en       = 1'b1;
            in_valid = 1'b1;
            in_sob   = 1'b0;
            in_eob   = 1'b0;
            in_sof   = 1'b1;
            in_data  = W'($urandom);
            tick();
        end
        fill(0, 1'b1);
        send_block(1'b0, -1, 1'b0, 10);
        fill(0, 1'b1);
        push_expected(1'b1);
        send_block(1'b1, K - 1, 1'b0, K);
        drain(K + 6);
        total++;
        if (cap.size() != exp_q.size()) begin
            bad++;
            $display("FAIL restart_count: %0d beats, want %0d", cap.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL restart_beat%0d: got %h, want %h", i, cap[i], exp_q[i]);
            end
        end
        total++;
        if (err_cnt != 0) begin
            bad++;
            $display("FAIL restart_err: %0d pulses, want 0", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        fill(0, 1'b1);
        send_block(1'b0, K - 1, 1'b0, K);
        for (int c = 0; c < 80 && cap.size() < 12; c++) tick();
        total++;
        if (cap.size() < 12) begin
            bad++;
            $display("FAIL rstmid_timeout: %0d beats seen, want 12", cap.size());
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_data, out_sob, out_eob, out_sof, out_err} !== '0) begin
            bad++;
            $display("FAIL rstmid_async: outputs %h, want 0", {out_valid, out_data, out_sob, out_eob, out_sof, out_err});
        end
        repeat (3) tick();
        rst_n = 1'b1;
        clear_logs();
        drain(K + 8);
        total++;
        if (cap.size() != 0) begin
            bad++;
            $display("FAIL rstmid_residual: %0d beats, want 0", cap.size());
        end
        fill(0, 1'b1);
        push_expected(1'b1);
        send_block(1'b1, K - 1, 1'b0, K);
        drain(K + 6);
        total++;
        if (cap.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rstmid_count: %0d beats, want %0d", cap.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rstmid_beat%0d: got %h, want %h", i, cap[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        build_zz();
        test_reset();
        test_single();
        test_back_to_back();
        test_en_toggle();
        test_eob_check();
        test_sob_restart();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/flow_zigzag.md
# flow_zigzag

Downstream stage of the quantization divider: takes quantized DCT coefficients of each 8x8 block, arriving in raster order at N coefficients per beat, and re-emits them in JPEG zigzag order with the same beat framing (sob/eob/sof). A two-bank ping-pong buffer lets the next block be written while the previous one is read out, so continuous input can be sustained. Output feeds the run-length/entropy encoder.

## Interface
- N, 2, coefficients per beat; legal values 1, 2, 4, 8; K = 64/N beats per block
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  global clock enable; when low, all state and outputs hold
- in_valid  in  1  input beat valid
- in_data  in  N x 16 signed  coefficients; lane i holds raster index beat*N+i
- in_sob  in  1  first beat of a block
- in_eob  in  1  last beat of a block
- in_sof  in  1  first block of a frame; meaningful on the sob beat
- out_valid  out  1  output beat valid
- out_data  out  N x 16 signed  lane j holds coefficient at zigzag position beat*N+j
- out_sob  out  1  first output beat of a block
- out_eob  out  1  last output beat of a block
- out_sof  out  1  on the sob beat of a block whose input sob beat carried in_sof
- out_err  out  1  one-cycle pulse on a framing error (see Configuration)

## Operation
- Storage: 2 banks x 64 x 16-bit registers; each bank has a full flag and a captured sof bit.
- Writer: idle until an in_valid beat with in_sob; that beat writes to index 0..N-1 of the current write bank and captures in_sof. Beat counter wc runs 0..K-1; lane i writes address wc*N+i.
- in_valid without in_sob while writer idle: beat dropped.
- in_sob while writer mid-block: partial block discarded, writing restarts at wc=0 in the same bank.
- Block completes on the beat with wc=K-1: bank full flag set, write bank toggles, writer returns to idle.
- Writer never writes into a bank that is full or being read. Sustained input of one beat per en-cycle never conflicts; if the target bank is still occupied, the incoming block is dropped and out_err pulses.
- Reader: idle or reading. When idle and a bank is full, it starts that bank; when finishing a bank (beat K-1) and the other bank is full, it starts the other bank on the next beat with no gap. Bank full flag clears when its beat K-1 is issued.
- Reader beat rc: lane j = bank[ZZ[rc*N+j]], ZZ being the standard 64-entry JPEG zigzag table (0,1,8,16,9,2,3,10,17,24,... ,55,62,63). out_sob at rc=0, out_eob at rc=K-1, out_sof = captured sof on rc=0 only.
- Data is passed unmodified; no saturation or sign change.

## Timing
- Reset: all outputs 0, both banks empty, writer and reader idle, counters 0. Bank contents need not reset.
- All counters, flags, and output registers advance only on edges where en=1.
- Latency: eob beat sampled at edge E -> out beat 0 registered at edge E+1 -> out beat K-1 at edge E+K. out_valid is contiguous for K en-cycles.
- Back-to-back blocks at full rate produce back-to-back output blocks with no bubble.
- Block and reset: rst_n asserted mid-block discards both banks immediately. Output resumes only after a fresh sob.
- out_err: registered, high for exactly one en-cycle.

## Configuration
- FLOW_ZIGZAG_CHECK_EN defined: in_eob is checked against wc. An in_eob beat with wc!=K-1, or a wc=K-1 beat without in_eob, discards the block (bank stays empty), returns the writer to idle, and pulses out_err.
- FLOW_ZIGZAG_CHECK_EN undefined: in_eob is ignored and completion is by count only. out_err pulses only on the bank-occupied drop.

## Test plan
- Single block, N=2, in_data = raster index (beat b: {2b, 2b+1}), sob at b=0, eob at b=31 -> out beats {0,1}, {8,16}, {9,2}, ..., {62,63}; out_sob on beat 0, out_eob on beat 31; first output one edge after the eob edge.
- Three blocks back-to-back at full rate, sof on the first only, data offset by 100 per block -> 96 contiguous output beats, zigzag correct per block, out_sof only on the first block's beat 0.
- en toggled pseudo-randomly (50%) during input and output -> output sequence identical to the en=1 run, and outputs hold while en=0.
- With FLOW_ZIGZAG_CHECK_EN: eob at beat 20, then a clean block -> first block produces no output and out_err pulses once; second block is output correctly. Without the macro: eob ignored and no error pulse.
- sob re-asserted at beat 10 of a block, then 32 clean beats -> only the restarted block is output; beats before the sob are dropped while idle.
- rst_n pulsed low while a block is mid-readout, at output beat 12 -> all outputs 0 at once; no residual beats after release; the next clean block is output correctly.
